// File: rtl/fa_serial_seq_if.sv
// fa_serial_seq operand/result handshake bundle.
// master drives operands and result-ready; slave is the sequencer.
interface fa_serial_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_gp;
  logic             out_gg;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_cout, out_gp, out_gg
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum,
    output out_cout, out_gp, out_gg
  );
endinterface

// File: rtl/fa_serial_seq.sv
// Bit-serial adder sequencer around an external
// full_adder_cp cell, LSB first, one bit per cycle.
module fa_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  fa_serial_seq_if.slave bus,
  output logic           err,
  output logic           fa_a,
  output logic           fa_b,
  output logic           fa_cin,
  input  logic           fa_prop,
  input  logic           fa_gen,
  input  logic           fa_sout
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             carry_d;
  logic             gp_q;
  logic             gp_d;
  logic             gg_q;
  logic             gg_d;

  logic [WIDTH-1:0] res_sum_q;
  logic             res_cout_q;
  logic             res_gp_q;
  logic             res_gg_q;

  logic idle;
  logic run;
  logic last;
  logic accept;

  assign idle   = (state_q == IDLE);
  assign run    = (state_q == RUN);
  assign last   = (idx_q == LAST);
  assign accept = idle & bus.in_valid;

  // in_ready is gated by rst_n so it reads low during reset
  assign bus.in_ready  = idle & rst_n;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = res_sum_q;
  assign bus.out_cout  = res_cout_q;
  assign bus.out_gp    = res_gp_q;
  assign bus.out_gg    = res_gg_q;

  assign fa_a   = run ? a_q[idx_q] : 1'b0;
  assign fa_b   = run ? b_q[idx_q] : 1'b0;
  assign fa_cin = run ? carry_q    : 1'b0;

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // per-bit accumulation from the cell outputs
  always_comb begin
    sum_d        = sum_q;
    sum_d[idx_q] = fa_sout;
    carry_d      = fa_gen | (fa_prop & carry_q);
    gp_d         = gp_q & fa_prop;
    gg_d         = fa_gen | (fa_prop & gg_q);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // operand latch and serial datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      gp_q    <= 1'b0;
      gg_q    <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.in_a;
      b_q     <= bus.in_b;
      carry_q <= bus.in_cin;
      sum_q   <= '0;
      idx_q   <= '0;
      gp_q    <= 1'b1;
      gg_q    <= 1'b0;
    end else if (run) begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      gp_q    <= gp_d;
      gg_q    <= gg_d;
      if (!last) idx_q <= idx_q + IW'(1);
    end
  end

  // result registers load on the last bit and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
      res_gp_q   <= 1'b0;
      res_gg_q   <= 1'b0;
    end else if (run && last) begin
      res_sum_q  <= sum_d;
      res_cout_q <= carry_d;
      res_gp_q   <= gp_d;
      res_gg_q   <= gg_d;
    end
  end

  // sticky cell-consistency fault
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (run && (fa_sout != (fa_prop ^ carry_q))) err <= 1'b1;
  end

endmodule

// File: tb/tb_fa_serial_seq.sv
// Self-checking bench for fa_serial_seq with a
// behavioural full_adder_cp cell and arithmetic model.
module tb_fa_serial_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  logic fa_a, fa_b, fa_cin;
  logic fa_prop, fa_gen, fa_sout;
  logic inj = 1'b0;

  always #5 clk = ~clk;

  fa_serial_seq_if #(.WIDTH(W)) bus ();

  assign fa_prop = fa_a ^ fa_b;
  assign fa_gen  = fa_a & fa_b;
  assign fa_sout = fa_a ^ fa_b ^ fa_cin ^ inj;

  fa_serial_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err     (err),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_prop (fa_prop),
    .fa_gen  (fa_gen),
    .fa_sout (fa_sout)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         gp;
    logic         gg;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic void model(input  logic [W-1:0] a,
                                input  logic [W-1:0] b,
                                input  logic         cin,
                                output logic [W-1:0] s,
                                output logic         co,
                                output logic         gp,
                                output logic         gg);
    logic [W:0] t;
    logic [W:0] t0;
    t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    t0 = {1'b0, a} + {1'b0, b};
    s  = t[W-1:0];
    co = t[W];
    gp = &(a ^ b);
    gg = t0[W];
  endfunction

  // called at a negedge; returns #1 after the accepting edge
  task automatic send(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic cin);
    int n;
    n = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    bus.in_cin   = 1'($urandom);
  endtask

  // counts edges since accept until out_valid is seen
  task automatic wait_out(input int start, output int lat);
    lat = start;
    @(negedge clk);
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic check_res(input string tag,
                           input logic [W-1:0] s,
                           input logic co,
                           input logic gp,
                           input logic gg);
    check({tag, "_sum"},  32'(bus.out_sum),  32'(s));
    check({tag, "_cout"}, 32'(bus.out_cout), 32'(co));
    check({tag, "_gp"},   32'(bus.out_gp),   32'(gp));
    check({tag, "_gg"},   32'(bus.out_gg),   32'(gg));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_outs"},
          32'({bus.out_sum, bus.out_cout, bus.out_gp, bus.out_gg}), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_fa"}, 32'({fa_a, fa_b, fa_cin}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] a, b, s;
    logic cin, co, gp, gg;
    logic [W-1:0] held;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'hF0, 8'h0E, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.in_ready), 32'd1);

    // directed table
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin);
      wait_out(1, lat);
      check($sformatf("tbl%0d_lat", i), 32'(lat), 32'd9);
      check_res($sformatf("tbl%0d", i),
                tbl[i].s, tbl[i].co, tbl[i].gp, tbl[i].gg);
      check($sformatf("tbl%0d_err", i), 32'(err), 32'd0);
      check($sformatf("tbl%0d_ready", i), 32'(bus.in_ready), 32'd0);
      release_out();
      check($sformatf("tbl%0d_idle", i), 32'(bus.out_valid), 32'd0);
    end

    // backpressure with new operands pending
    send(8'h12, 8'h34, 1'b0);
    wait_out(1, lat);
    check("bp_lat", 32'(lat), 32'd9);
    check_res("bp", 8'h46, 1'b0, 1'b0, 1'b0);
    held = bus.out_sum;
    bus.in_a     = 8'h0F;
    bus.in_b     = 8'h01;
    bus.in_cin   = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_hold%0d_sum", k), 32'(bus.out_sum), 32'(held));
      check($sformatf("bp_hold%0d_ready", k), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    check("bp_idle_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_accepted", 32'(bus.in_ready), 32'd0);
    wait_out(1, lat);
    check("bp_next_lat", 32'(lat), 32'd9);
    check_res("bp_next", 8'h10, 1'b0, 1'b0, 1'b0);
    release_out();

    // reset in the middle of RUN at idx 4
    send(8'hC3, 8'h7E, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrun");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrun_ready", 32'(bus.in_ready), 32'd1);
    check("midrun_novalid", 32'(bus.out_valid), 32'd0);
    send(8'h5A, 8'h3C, 1'b0);
    wait_out(1, lat);
    check("post_rst_lat", 32'(lat), 32'd9);
    check_res("post_rst", 8'h96, 1'b0, 1'b0, 1'b0);
    release_out();

    // randomized against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      model(a, b, cin, s, co, gp, gg);
      send(a, b, cin);
      wait_out(1, lat);
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd9);
      check_res($sformatf("rnd%0d", i), s, co, gp, gg);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check($sformatf("rnd%0d_hold", i), 32'(bus.out_sum), 32'(s));
      release_out();
    end
    check("rnd_err", 32'(err), 32'd0);

    // fault injection on bit 3
    send(8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    inj = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    wait_out(5, lat);
    check("fault_lat", 32'(lat), 32'd9);
    check_res("fault", 8'h08, 1'b0, 1'b0, 1'b0);
    check("fault_err", 32'(err), 32'd1);
    release_out();

    model(8'h21, 8'h43, 1'b0, s, co, gp, gg);
    send(8'h21, 8'h43, 1'b0);
    wait_out(1, lat);
    check_res("after_fault", s, co, gp, gg);
    check("err_sticky", 32'(err), 32'd1);
    release_out();
    check("err_sticky_idle", 32'(err), 32'd1);

    rst_n = 1'b0;
    #1;
    check("err_cleared", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fa_serial_seq.md
# fa_serial_seq

Bit-serial add sequencer wrapped around a single `full_adder_cp` propagate/generate cell. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then drives the cell one bit per cycle, LSB first. On each cycle it feeds the cell's carry back and captures the cell's sum. It returns the WIDTH-bit sum, carry-out and word-level group propagate/generate over a second valid/ready handshake. The block is both the cell's upstream driver and its downstream consumer; the cell is instantiated outside and connected through the `fa_*` ports.

## Interface
- WIDTH, 8, operand/sum width in bits (≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  initial carry
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  sum
- out_cout  out  1  final carry
- out_gp  out  1  group propagate (AND of all bit propagates)
- out_gg  out  1  group generate (carry-out assuming cin=0)
- err  out  1  sticky cell-consistency fault
- fa_a, fa_b, fa_cin  out  1 each  cell operand bits and carry-in
- fa_prop, fa_gen, fa_sout  in  1 each  cell outputs, combinational from fa_a/fa_b/fa_cin; prop=a^b, gen=a&b

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a, in_b and in_cin into carry_reg.
  - Clear idx, sum_reg, gg_reg; set gp_reg=1; go to RUN.
- RUN, one cycle per bit idx=0..WIDTH-1:
  - Drive fa_a=a_reg[idx], fa_b=b_reg[idx], fa_cin=carry_reg.
  - At the clock edge:
    - sum_reg[idx] ← fa_sout
    - carry_reg ← fa_gen | (fa_prop & carry_reg)
    - gp_reg ← gp_reg & fa_prop
    - gg_reg ← fa_gen | (fa_prop & gg_reg)
  - When idx==WIDTH-1, go to DONE. idx is not incremented past WIDTH-1 and does not wrap.
- Fault check in RUN: if fa_sout != (fa_prop ^ carry_reg), set err. err is cleared only by reset.
- DONE:
  - out_valid=1.
  - out_sum=sum_reg, out_cout=carry_reg, out_gp=gp_reg, out_gg=gg_reg, all held stable.
  - On out_ready go to IDLE.
- in_ready=0 in RUN and DONE. in_valid is ignored there, and in_a/in_b/in_cin may change freely.
- Outside RUN, fa_a, fa_b and fa_cin are driven 0.
- Result outputs are registered. They keep their last values in IDLE and RUN; only out_valid qualifies them.

## Timing
- Reset values:
  - in_ready reads 0 while rst_n is low, and 1 from the first cycle after release.
  - out_valid=0, out_sum=0, out_cout=0, out_gp=0, out_gg=0, err=0.
  - fa_a, fa_b, fa_cin = 0.
- Latency:
  - Input accepted at edge 0.
  - RUN occupies edges 1..WIDTH.
  - out_valid is high in the cycle after edge WIDTH: 9 cycles of latency for WIDTH=8.
- Throughput: one operation per WIDTH+2 cycles at best. This is 1 IDLE cycle + WIDTH RUN cycles + at least 1 DONE cycle, with no overlap.
- Backpressure: DONE persists for any number of cycles with out_ready=0; outputs do not change.
- Reset mid-RUN or mid-DONE:
  - Immediate asynchronous return to IDLE with all reset values.
  - The partial result is discarded and no out_valid is produced.
- out_valid&out_ready and in_valid in the same cycle: the input is not accepted that cycle and is accepted in the following IDLE cycle.

## Test plan
- A=0x5A, B=0x3C, cin=0 -> out_valid 9 cycles after accept; sum=0x96, cout=0, gp=0, gg=0, err=0.
- A=0xFF, B=0x01, cin=0 -> sum=0x00, cout=1, gp=0, gg=1.
- A=0xAA, B=0x55, cin=1 -> sum=0x00, cout=1, gp=1, gg=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands throughout:
  - Outputs stay constant and in_ready stays 0.
  - Raising out_ready gives IDLE next cycle; the new operands are accepted the cycle after.
- Reset asserted during RUN at idx=4 -> all outputs at reset values, FSM in IDLE. The following 0x5A+0x3C still yields 0x96.
- Fault injection: invert fa_sout at idx=3 on 0x00+0x00 -> err=1 and sum=0x08. err remains 1 through subsequent clean operations until reset.
